// File: rtl/serial_frame_receiver.sv
// -----------------------------------------------------------------------------
// serial_frame_receiver
//
// Rebuilds framed words from an LSB-first serial bitstream. A frame is a start
// bit (1), DATA_W data bits LSB first, an optional parity bit and a stop bit
// (0). The line idles low. Each good frame is delivered through a single-word
// valid/ready output buffer.
//
// Parameters
//   DATA_W      data bits per frame (2..16)
//   PARITY_EN   1: a parity bit follows the data, 0: no parity bit
//   ODD_PARITY  1: odd parity, 0: even parity (used only when PARITY_EN=1)
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   serial_in   line bit, sampled only while bit_valid=1
//   bit_valid   qualifies serial_in, one cycle per transmitted bit
//   data_out    received word, stable while data_valid=1
//   data_valid  data_out holds an unconsumed word
//   data_ready  consumer accepts the word when data_valid & data_ready
//   parity_err  parity flag of the word on data_out (meaningful with data_valid)
//   frame_err   one-cycle pulse: the sampled stop bit was 1
//   overrun     one-cycle pulse: a good frame was dropped, buffer full
//   busy        1 whenever a frame is in progress
// -----------------------------------------------------------------------------
module serial_frame_receiver #(
  parameter int DATA_W     = 4,
  parameter int PARITY_EN  = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  // state    | meaning
  // S_IDLE   | line idle, waiting for a sampled 1 (start bit)
  // S_DATA   | collecting data bits into shreg, LSB first
  // S_PARITY | checking the parity bit against the collected data
  // S_STOP   | sampling the stop bit, then deliver / drop / flag the frame
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  localparam int                CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DATA_W - 1);
  localparam logic              ODD_BIT = (ODD_PARITY != 0);
  localparam logic              PAR_ON  = (PARITY_EN != 0);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                p_err_q, p_err_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                perr_out_q, perr_out_d;
  logic                valid_q, valid_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;

  logic                good_stop;
  logic                accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      p_err_q     <= 1'b0;
      data_q      <= '0;
      perr_out_q  <= 1'b0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      p_err_q     <= p_err_d;
      data_q      <= data_d;
      perr_out_q  <= perr_out_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    p_err_d     = p_err_q;
    data_d      = data_q;
    perr_out_d  = perr_out_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    good_stop   = 1'b0;

    // Frame FSM advances only on qualified bit cycles.
    if (bit_valid) begin
      case (state_q)
        S_IDLE: begin
          if (serial_in) begin
            state_d = S_DATA;
            cnt_d   = '0;
            // Cleared here so a parity-less build always reports 0.
            p_err_d = 1'b0;
          end
        end
        S_DATA: begin
          shreg_d[cnt_q] = serial_in;
          if (cnt_q == LAST) begin
            state_d = PAR_ON ? S_PARITY : S_STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_PARITY: begin
          p_err_d = ((^shreg_q) ^ serial_in) != ODD_BIT;
          state_d = S_STOP;
        end
        S_STOP: begin
          // The stop bit is never treated as the next start bit.
          state_d = S_IDLE;
          if (serial_in) begin
            frame_err_d = 1'b1;
          end else begin
            good_stop = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Output buffer: a load may coincide with the consumer taking the old
    // word, in which case the new word simply replaces it.
    accept = valid_q & data_ready;
    if (good_stop) begin
      if (!valid_q || data_ready) begin
        data_d     = shreg_q;
        perr_out_d = p_err_q;
        valid_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

`ifndef SYNTHESIS
  a_err_excl: assert property (@(posedge clk) disable iff (reset)
                               !(frame_err && overrun));
`endif

endmodule

// File: tb/tb_serial_frame_receiver.sv
module tb_serial_frame_receiver;

  localparam int DW  = 4;
  localparam int PEN = 1;
  localparam int ODD = 0;
  localparam int L   = DW + PEN + 1;  // bits after the start bit

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          serial_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          data_ready = 1'b0;
  logic          parity_err;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  int checks = 0;
  int errors = 0;

  serial_frame_receiver #(.DATA_W(DW), .PARITY_EN(PEN), .ODD_PARITY(ODD)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (frame level) ----------------
  bit          m_inf;
  int          m_n;
  bit          m_bits [L];
  bit          m_valid, m_perr, m_fe, m_ov;
  logic [DW-1:0] m_data;
  bit          m_load, m_acc, m_nperr;
  logic [DW-1:0] m_ndata;
  int          m_ones;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_inf = 0; m_n = 0; m_valid = 0; m_perr = 0; m_fe = 0; m_ov = 0;
      m_data = '0;
    end else begin
      m_fe = 0; m_ov = 0; m_load = 0;
      m_acc = m_valid && data_ready;
      if (bit_valid) begin
        if (!m_inf) begin
          if (serial_in) begin m_inf = 1; m_n = 0; end
        end else begin
          m_bits[m_n] = serial_in;
          m_n++;
          if (m_n == L) begin
            m_ones = 0;
            for (int i = 0; i < DW; i++) begin
              m_ndata[i] = m_bits[i];
              m_ones += int'(m_bits[i]);
            end
            if (PEN != 0) begin
              m_ones += int'(m_bits[DW]);
              m_nperr = ((m_ones % 2) != ODD);
            end else begin
              m_nperr = 0;
            end
            if (m_bits[L-1]) m_fe = 1;
            else if (m_valid && !data_ready) m_ov = 1;
            else m_load = 1;
            m_inf = 0;
          end
        end
      end
      if (m_load) begin
        m_valid = 1; m_data = m_ndata; m_perr = m_nperr;
      end else if (m_acc) begin
        m_valid = 0;
      end
    end
  end

  // Compare every cycle, on the falling edge.
  always @(negedge clk) begin
    chk("data_valid", 32'(data_valid), 32'(m_valid));
    chk("data_out",   32'(data_out),   32'(m_data));
    if (m_valid) chk("parity_err", 32'(parity_err), 32'(m_perr));
    chk("frame_err",  32'(frame_err),  32'(m_fe));
    chk("overrun",    32'(overrun),    32'(m_ov));
    chk("busy",       32'(busy),       32'(m_inf));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic sin, input logic bv);
    @(posedge clk); #1;
    serial_in = sin;
    bit_valid = bv;
  endtask

  // Frame 1, d[0..3], parity, stop; gap idle cycles between strobes.
  task automatic send_frame(input logic [3:0] d, input bit par_ok, input bit stop, input int gap);
    logic fb [7];
    logic p;
    p = (^d) ^ (par_ok ? 1'b0 : 1'b1);
    fb[0] = 1'b1;
    for (int i = 0; i < 4; i++) fb[i+1] = d[i];
    fb[5] = p;
    fb[6] = stop;
    for (int i = 0; i < 7; i++) begin
      drive(fb[i], 1'b1);
      if (i != 6) repeat (gap) drive(1'b0, 1'b0);
    end
    drive(1'b0, 1'b0);  // stop bit sampled at this edge
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_data",  32'(data_out), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    data_ready = 1'b1;

    // 1: good frame D
    send_frame(4'hD, 1, 0, 0);
    chk("t1_valid", 32'(data_valid), 32'd1);
    chk("t1_data",  32'(data_out), 32'hD);
    chk("t1_perr",  32'(parity_err), 32'd0);
    chk("t1_model", 32'(m_data), 32'hD);
    repeat (2) drive(1'b0, 1'b0);

    // 2: parity error
    send_frame(4'hD, 0, 0, 0);
    chk("t2_data",  32'(data_out), 32'hD);
    chk("t2_perr",  32'(parity_err), 32'd1);
    chk("t2_valid", 32'(data_valid), 32'd1);
    repeat (2) drive(1'b0, 1'b0);

    // 3: bad stop bit, then frame 8
    send_frame(4'h5, 1, 1, 0);
    chk("t3_ferr",  32'(frame_err), 32'd1);
    chk("t3_valid", 32'(data_valid), 32'd0);
    drive(1'b0, 1'b0);
    chk("t3_ferr_pulse", 32'(frame_err), 32'd0);
    send_frame(4'h8, 1, 0, 0);
    chk("t3_data",  32'(data_out), 32'h8);
    chk("t3_perr",  32'(parity_err), 32'd0);
    repeat (2) drive(1'b0, 1'b0);

    // 4: overrun with consumer stalled
    data_ready = 1'b0;
    send_frame(4'h3, 1, 0, 0);
    chk("t4_valid1", 32'(data_valid), 32'd1);
    chk("t4_data1",  32'(data_out), 32'h3);
    send_frame(4'hA, 1, 0, 0);
    chk("t4_ovr",    32'(overrun), 32'd1);
    chk("t4_data2",  32'(data_out), 32'h3);
    chk("t4_valid2", 32'(data_valid), 32'd1);
    drive(1'b0, 1'b0);
    chk("t4_ovr_pulse", 32'(overrun), 32'd0);
    data_ready = 1'b1;
    drive(1'b0, 1'b0);
    chk("t4_drain", 32'(data_valid), 32'd0);

    // 5: sparse strobes
    send_frame(4'hD, 1, 0, 2);
    chk("t5_data", 32'(data_out), 32'hD);
    chk("t5_perr", 32'(parity_err), 32'd0);
    chk("t5_valid", 32'(data_valid), 32'd1);
    repeat (2) drive(1'b0, 1'b0);

    // 6: reset mid-frame
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    @(posedge clk); #1 reset = 1'b1; bit_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    send_frame(4'h5, 1, 0, 0);
    chk("t6_data",  32'(data_out), 32'h5);
    chk("t6_valid", 32'(data_valid), 32'd1);
    chk("t6_ferr",  32'(frame_err), 32'd0);
    chk("t6_ovr",   32'(overrun), 32'd0);
    repeat (3) drive(1'b0, 1'b0);

    // random phase
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
      end else begin
        reset = 1'b0;
      end
      bit_valid  = ($urandom_range(0, 3) != 0);
      serial_in  = 1'($urandom_range(0, 1));
      data_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1 reset = 1'b0; bit_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
